// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int TO_CNT_W = 16;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles and flags the LIMIT-th one.
module wb_timeout_ctr
    import wb_cmd_master_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(LIMIT - 1);

    logic [TO_CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Asserted during the LIMIT-th enabled cycle, so the abort lands on that edge.
    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master driven by a valid/ready command port.
// Optional bus watchdog enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADR_W-1:0]     cmd_adr_i,
    input  logic [DAT_W-1:0]     cmd_dat_i,
    input  logic [DAT_W/8-1:0]   cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_W-1:0]     rsp_dat_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADR_W-1:0]     wb_adr_o,
    output logic [DAT_W-1:0]     wb_dat_o,
    output logic [DAT_W/8-1:0]   wb_sel_o,
    input  logic [DAT_W-1:0]     wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i
);

    localparam int SEL_W = DAT_W / 8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
    end

    state_t             state_q, state_d;
    logic               we_q;
    logic [ADR_W-1:0]   adr_q;
    logic [DAT_W-1:0]   dat_q;
    logic [SEL_W-1:0]   sel_q;
    logic [DAT_W-1:0]   rsp_dat_q;
    logic               rsp_err_q;
    logic               rsp_to_q;
    logic               cmd_fire;
    logic               bus_done;
    logic               to_expired;

    assign cmd_fire = cmd_valid_i && (state_q == ST_IDLE);
    assign bus_done = wb_ack_i || wb_err_i;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .enable  (state_q == ST_BUS),
        .clear   (state_q != ST_BUS),
        .expired (to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid_i)              state_d = ST_BUS;
            ST_BUS:  if (bus_done || to_expired)   state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i)              state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_to_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                we_q  <= cmd_we_i;
                adr_q <= cmd_adr_i;
                dat_q <= cmd_dat_i;
                sel_q <= cmd_sel_i;
            end
            // A slave reply on the expiry cycle wins over the watchdog.
            if (state_q == ST_BUS) begin
                if (bus_done) begin
                    rsp_dat_q <= we_q ? '0 : wb_dat_i;
                    rsp_err_q <= wb_err_i;
                    rsp_to_q  <= 1'b0;
                end else if (to_expired) begin
                    rsp_dat_q <= '0;
                    rsp_err_q <= 1'b1;
                    rsp_to_q  <= 1'b1;
                end
            end
        end
    end

    // Bus strobes come straight from the state flop, so reset drops them without a clock.
    assign wb_cyc_o    = (state_q == ST_BUS);
    assign wb_stb_o    = (state_q == ST_BUS);
    assign wb_we_o     = wb_cyc_o ? we_q  : 1'b0;
    assign wb_adr_o    = wb_cyc_o ? adr_q : '0;
    assign wb_dat_o    = wb_cyc_o ? dat_q : '0;
    assign wb_sel_o    = wb_cyc_o ? sel_q : '0;

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    assign rsp_timeout_o = rsp_to_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADR_W, default 32, Wishbone address width.
REQ-002 SHALL have parameter DAT_W, default 32, Wishbone data width; SEL width is DAT_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, bus cycles waited for ack/err before abort; legal range 1..65535.
REQ-004 SHALL have port wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1: command handshake.
REQ-007 SHALL have ports cmd_we_i in 1, cmd_adr_i in ADR_W, cmd_dat_i in DAT_W, cmd_sel_i in DAT_W/8: command payload.
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-009 SHALL have ports rsp_dat_o out DAT_W (read data), rsp_err_o out 1 (slave err or timeout), rsp_timeout_o out 1 (timeout cause).
REQ-010 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out ADR_W; wb_dat_o out DAT_W; wb_sel_o out DAT_W/8: Wishbone classic master outputs.
REQ-011 SHALL have ports wb_dat_i in DAT_W, wb_ack_i in 1, wb_err_i in 1: Wishbone slave responses.

Function
REQ-012 SHALL implement FSM states IDLE, BUS, RESP; cmd_ready_o = (state==IDLE).
REQ-013 SHALL, on cmd_valid_i && cmd_ready_o, register we/adr/dat/sel and enter BUS; wb_cyc_o/wb_stb_o assert on the next cycle (1-cycle command-to-bus latency).
REQ-014 SHALL hold wb_cyc_o, wb_stb_o and all Wishbone outputs stable throughout BUS.
REQ-015 SHALL, in BUS, on wb_ack_i or wb_err_i sampled high, deassert cyc/stb on the following cycle, capture wb_dat_i into rsp_dat_o (reads only; writes leave rsp_dat_o at 0), set rsp_err_o=wb_err_i, enter RESP.
REQ-016 SHALL give err priority when wb_ack_i and wb_err_i are high together (rsp_err_o=1).
REQ-017 SHALL ignore wb_ack_i/wb_err_i outside BUS.
REQ-018 SHALL assert rsp_valid_o in RESP, holding payload stable until rsp_ready_i; on handshake return to IDLE, clearing rsp_valid_o.
REQ-019 SHALL permit at most one outstanding transaction; a new command is accepted no earlier than the cycle after response handshake (back-to-back minimum 3 cycles per transaction with zero-wait slave).
REQ-020 SHALL drive wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o to 0 when wb_cyc_o is low.

Reset
REQ-021 SHALL, on wb_rst_n_i low, immediately (asynchronously) force state IDLE, cyc/stb/we/rsp_valid/rsp_err/rsp_timeout to 0, adr/dat/sel/rsp_dat to 0, timeout counter to 0.
REQ-022 SHALL abandon any in-flight bus cycle or pending response on reset without emitting a response.
REQ-023 SHALL deassert reset synchronously to the design (release sampled on a clock edge); first command acceptable the cycle after release.

Configuration
REQ-024 SHALL, with WB_CMD_MASTER_TIMEOUT_EN defined, count BUS cycles; if TIMEOUT_CYCLES elapse with no ack/err, drop cyc/stb, set rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0, enter RESP.
REQ-025 SHALL, without WB_CMD_MASTER_TIMEOUT_EN, omit the counter, wait indefinitely in BUS and tie rsp_timeout_o to 0.
REQ-026 SHALL treat ack/err arriving on the same cycle the timeout expires as a normal termination (rsp_timeout_o=0).

Structure
REQ-027 SHALL place the state enum type and the TIMEOUT counter width constant (16) in package wb_cmd_master_pkg.
REQ-028 SHALL implement the timeout counter as sub-module wb_timeout_ctr (enable, clear, expired), instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

Verification
REQ-029 Write: cmd we=1 adr=0x0 dat=0xEEEEEEEE sel=0xE, slave acks after 2 waits -> cyc/stb high 3 cycles, wb_sel_o=0xE, rsp_valid with rsp_err=0.
REQ-030 Read: cmd we=0 adr=0x0, slave returns 0xEEEEEE00 with ack -> rsp_dat_o=0xEEEEEE00, rsp_err=0.
REQ-031 Error: slave asserts ack and err together -> rsp_err_o=1, rsp_timeout_o=0.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=8): no ack -> cyc drops after 8 BUS cycles, rsp_err=1, rsp_timeout=1; macro off -> cyc stays high 100 cycles.
REQ-033 Backpressure: rsp_ready low 5 cycles -> rsp payload stable, cmd_ready_o low throughout.
REQ-034 Reset mid-BUS: wb_rst_n_i low during wait state -> cyc/stb low without clock edge, no response after release.
